// File: rtl/r200_pkg.sv
// Shared R200 pipeline constants: datapath width, NOP word and fetch pc-select encodings.
package r200_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSEL_P4   = 2'd0,
    PCSEL_BR   = 2'd1,
    PCSEL_JUMP = 2'd2,
    PCSEL_HOLD = 2'd3
  } pcsel_e;

endpackage

// File: rtl/r200_ifid_q.sv
// Fetch/decode decoupling queue: FWFT storage of {instrn, pc, pcp4} with flush and
// a held re-fetch address for fetches the queue had to refuse.
module r200_ifid_q
  import r200_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = r200_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_valid,
  input  logic [XLEN-1:0]            if_instrn,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_pcp4,
  output logic                       if_ready,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_instrn,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_pcp4,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            hold_pc,
  output logic                       fetch_hold,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] mem_instrn [DEPTH];
  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic [XLEN-1:0] mem_pcp4   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          enq;
  logic          deq;

  // Full blocks enqueue even when decode drains this cycle, keeping if_ready off id_ready.
  assign if_ready   = (count != FULL_CNT);
  assign id_valid   = (count != '0);
  assign fetch_hold = if_valid & ~if_ready & ~flush;
  assign enq        = if_valid & if_ready & ~flush;
  assign deq        = id_valid & id_ready & ~flush;

  assign id_instrn = id_valid ? mem_instrn[rd_ptr] : '0;
  assign id_pc     = id_valid ? mem_pc[rd_ptr]     : '0;
  assign id_pcp4   = id_valid ? mem_pcp4[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instrn[i] <= '0;
        mem_pc[i]     <= '0;
        mem_pcp4[i]   <= '0;
      end
    end else if (enq) begin
      mem_instrn[wr_ptr] <= if_instrn;
      mem_pc[wr_ptr]     <= if_pc;
      mem_pcp4[wr_ptr]   <= if_pcp4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          hold_pc <= '0;
    else if (fetch_hold) hold_pc <= if_pc;
  end

endmodule

// File: tb/tb_r200_ifid_q.sv
// Directed bench for r200_ifid_q (DEPTH=2): fill/refuse, full drain, simultaneous
// enq/deq, flush, pointer wrap and asynchronous reset.
module tb_r200_ifid_q;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_valid;
  logic [XLEN-1:0] if_instrn;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pcp4;
  logic            if_ready;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_instrn;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pcp4;
  logic            id_ready;
  logic [XLEN-1:0] hold_pc;
  logic            fetch_hold;
  logic [1:0]      count;

  int checks = 0;
  int errors = 0;

  r200_ifid_q #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instrn(if_instrn), .if_pc(if_pc), .if_pcp4(if_pcp4),
    .if_ready(if_ready), .flush(flush),
    .id_valid(id_valid), .id_instrn(id_instrn), .id_pc(id_pc), .id_pcp4(id_pcp4),
    .id_ready(id_ready), .hold_pc(hold_pc), .fetch_hold(fetch_hold), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction word derived from pc; pc 0 carries the NOP word to show it is queued normally.
  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return (pc == '0) ? 32'h0000_0000 : (pc | 32'hA500_0013);
  endfunction

  task automatic present(input logic v, input logic [XLEN-1:0] pc);
    if_valid  = v;
    if_pc     = pc;
    if_pcp4   = pc + 32'd4;
    if_instrn = instr_of(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0;
    present(1'b1, 32'h0000_0100);
    #12;
    checks++; if (count !== 2'd0)   begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
    checks++; if (fetch_hold !== 1'b0) begin errors++; $display("FAIL reset_fetch_hold got %b want 0", fetch_hold); end
    checks++; if (hold_pc !== 32'h0) begin errors++; $display("FAIL reset_hold_pc got %h want 0", hold_pc); end
    checks++; if (id_pc !== 32'h0 || id_instrn !== 32'h0 || id_pcp4 !== 32'h0)
      begin errors++; $display("FAIL reset_id_zero got pc=%h instr=%h pcp4=%h want 0", id_pc, id_instrn, id_pcp4); end
    present(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_refuse;
    id_ready = 1'b0;
    present(1'b1, 32'h0);
    tick;
    checks++; if (count !== 2'd1 || id_valid !== 1'b1)
      begin errors++; $display("FAIL fill1 got count=%0d valid=%b want 1/1", count, id_valid); end
    checks++; if (id_pc !== 32'h0 || id_instrn !== 32'h0 || id_pcp4 !== 32'h4)
      begin errors++; $display("FAIL fill1_nop got pc=%h instr=%h pcp4=%h want 0/0/4", id_pc, id_instrn, id_pcp4); end
    present(1'b1, 32'h4);
    tick;
    checks++; if (count !== 2'd2 || if_ready !== 1'b0)
      begin errors++; $display("FAIL fill2 got count=%0d ready=%b want 2/0", count, if_ready); end
    present(1'b1, 32'h8);
    #1;
    checks++; if (fetch_hold !== 1'b1) begin errors++; $display("FAIL refuse_fetch_hold got %b want 1", fetch_hold); end
    tick;
    checks++; if (hold_pc !== 32'h8) begin errors++; $display("FAIL refuse_hold_pc got %h want 8", hold_pc); end
    checks++; if (count !== 2'd2 || id_pc !== 32'h0)
      begin errors++; $display("FAIL refuse_state got count=%0d pc=%h want 2/0", count, id_pc); end
  endtask

  task automatic test_full_drain;
    id_ready = 1'b1;
    present(1'b1, 32'h8);
    #1;
    checks++; if (if_ready !== 1'b0 || fetch_hold !== 1'b1)
      begin errors++; $display("FAIL full_bypass got ready=%b hold=%b want 0/1", if_ready, fetch_hold); end
    tick;
    checks++; if (count !== 2'd1 || id_pc !== 32'h4 || id_pcp4 !== 32'h8 || id_instrn !== 32'hA500_0017)
      begin errors++; $display("FAIL full_drain got count=%0d pc=%h pcp4=%h instr=%h want 1/4/8/a5000017", count, id_pc, id_pcp4, id_instrn); end
  endtask

  task automatic test_simul;
    id_ready = 1'b1;
    present(1'b1, 32'hC);
    #1;
    checks++; if (fetch_hold !== 1'b0) begin errors++; $display("FAIL simul_fetch_hold got %b want 0", fetch_hold); end
    tick;
    checks++; if (count !== 2'd1 || id_pc !== 32'hC)
      begin errors++; $display("FAIL simul got count=%0d pc=%h want 1/c", count, id_pc); end
    checks++; if (hold_pc !== 32'h8) begin errors++; $display("FAIL simul_hold_pc_kept got %h want 8", hold_pc); end
  endtask

  task automatic test_flush;
    id_ready = 1'b0;
    present(1'b1, 32'h10);
    tick;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre got count=%0d want 2", count); end
    flush = 1'b1;
    id_ready = 1'b1;
    present(1'b1, 32'h40);
    #1;
    checks++; if (fetch_hold !== 1'b0) begin errors++; $display("FAIL flush_fetch_hold got %b want 0", fetch_hold); end
    tick;
    flush = 1'b0;
    present(1'b0, 32'h0);
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || id_pc !== 32'h0)
      begin errors++; $display("FAIL flush got count=%0d valid=%b pc=%h want 0/0/0", count, id_valid, id_pc); end
    tick;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_no_enq got count=%0d want 0", count); end
  endtask

  task automatic test_back_to_back;
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      present(1'b1, 32'(4 * i));
      tick;
      checks++; if (count !== 2'd1 || id_pc !== 32'(4 * i) || id_pcp4 !== 32'(4 * i + 4))
        begin errors++; $display("FAIL b2b_%0d got count=%0d pc=%h pcp4=%h want 1/%h/%h", i, count, id_pc, id_pcp4, 4 * i, 4 * i + 4); end
    end
    present(1'b0, 32'h0);
    tick;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_drain got count=%0d valid=%b want 0/0", count, id_valid); end
    tick;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL underflow got count=%0d want 0", count); end
  endtask

  task automatic test_async_reset;
    id_ready = 1'b0;
    present(1'b1, 32'h80); tick;
    present(1'b1, 32'h84); tick;
    present(1'b1, 32'h88); tick;
    checks++; if (count !== 2'd2 || hold_pc !== 32'h88)
      begin errors++; $display("FAIL areset_pre got count=%0d hold=%h want 2/88", count, hold_pc); end
    present(1'b1, 32'h8C);
    id_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 2'd0 || id_valid !== 1'b0 || hold_pc !== 32'h0 || if_ready !== 1'b1)
      begin errors++; $display("FAIL areset got count=%0d valid=%b hold=%h ready=%b want 0/0/0/1", count, id_valid, hold_pc, if_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    present(1'b1, 32'h90);
    id_ready = 1'b0;
    tick;
    checks++; if (count !== 2'd1 || id_pc !== 32'h90)
      begin errors++; $display("FAIL areset_resume got count=%0d pc=%h want 1/90", count, id_pc); end
    present(1'b0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_fill_refuse;
    test_full_drain;
    test_simul;
    test_flush;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
